// File: rtl/mod_n_timer.sv
// Loadable cascaded modulo-N down-counter (default MM:SS countdown) with
// saturating stop at zero, done pulse, load clamping, optional auto-reload.
module mod_n_timer #(
  parameter int                            NUM_DIGITS  = 4,
  parameter int                            DIGIT_W     = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] MOD_LIST    = 16'hA_A_6_A,
  parameter bit                            AUTO_RELOAD = 1'b0
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          en,
  input  logic                          loadn,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] data,
  output logic [NUM_DIGITS*DIGIT_W-1:0] out,
  output logic [NUM_DIGITS-1:0]         tc,
  output logic                          zero,
  output logic                          done
);

  localparam int W = NUM_DIGITS * DIGIT_W;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_mod_chk
      if (MOD_LIST[gi*DIGIT_W +: DIGIT_W] < 2) begin : g_bad_mod
        $error("mod_n_timer: digit modulus must be at least 2");
      end
    end
  endgenerate

  function automatic logic [DIGIT_W-1:0] mod_of(input int idx);
    return MOD_LIST[idx*DIGIT_W +: DIGIT_W];
  endfunction

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                      input int idx);
    return (d >= mod_of(idx)) ? (mod_of(idx) - 1'b1) : d;
  endfunction

  logic [W-1:0]          r_out;
  logic [W-1:0]          r_rel;
  logic [NUM_DIGITS-1:0] r_tc;
  logic                  r_zero;
  logic                  r_done;

  logic [W-1:0]          w_dec;
  logic [W-1:0]          w_clamp;
  logic [NUM_DIGITS-1:0] w_wrap;
  logic                  w_dec_zero;
  logic                  w_clamp_zero;

  // Borrow ripples upward only through digits that are already 0;
  // a zero digit receiving a borrow wraps to its modulus minus one.
  always_comb begin
    logic                v_borrow;
    logic [DIGIT_W-1:0]  v_d;
    v_borrow = 1'b1;
    w_dec    = '0;
    w_clamp  = '0;
    w_wrap   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      v_d = r_out[i*DIGIT_W +: DIGIT_W];
      w_wrap[i] = v_borrow && (v_d == '0);
      if (!v_borrow)
        w_dec[i*DIGIT_W +: DIGIT_W] = v_d;
      else if (v_d == '0)
        w_dec[i*DIGIT_W +: DIGIT_W] = mod_of(i) - 1'b1;
      else
        w_dec[i*DIGIT_W +: DIGIT_W] = v_d - 1'b1;
      v_borrow = v_borrow && (v_d == '0);
      w_clamp[i*DIGIT_W +: DIGIT_W] = clamp_digit(data[i*DIGIT_W +: DIGIT_W], i);
    end
    w_dec_zero   = (w_dec == '0);
    w_clamp_zero = (w_clamp == '0);
  end

  // r_zero always mirrors (r_out == 0), so it doubles as the stop condition.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_out  <= '0;
      r_rel  <= '0;
      r_zero <= 1'b1;
      r_done <= 1'b0;
      r_tc   <= '0;
    end else if (!loadn) begin
      r_out  <= w_clamp;
      r_rel  <= w_clamp;
      r_zero <= w_clamp_zero;
      r_done <= 1'b0;
      r_tc   <= '0;
    end else if (en && !r_zero) begin
      r_out  <= w_dec;
      r_zero <= w_dec_zero;
      r_done <= w_dec_zero;
      r_tc   <= w_wrap;
    end else if (en && AUTO_RELOAD) begin
      r_out  <= r_rel;
      r_zero <= (r_rel == '0);
      r_done <= 1'b0;
      r_tc   <= '0;
    end else begin
      r_done <= 1'b0;
      r_tc   <= '0;
    end
  end

  assign out  = r_out;
  assign tc   = r_tc;
  assign zero = r_zero;
  assign done = r_done;

endmodule

// File: tb/tb_mod_n_timer.sv
// Directed bench for mod_n_timer: default MM:SS instance plus a
// two-digit auto-reload instance.
module tb_mod_n_timer;

  logic        clk = 1'b0;
  logic        clr, en, loadn;
  logic [15:0] data;
  logic [15:0] out;
  logic [3:0]  tc;
  logic        zero, done;

  logic        a_clr, a_en, a_loadn;
  logic [7:0]  a_data;
  logic [7:0]  a_out;
  logic [1:0]  a_tc;
  logic        a_zero, a_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mod_n_timer u_dut (
    .clk(clk), .clr(clr), .en(en), .loadn(loadn), .data(data),
    .out(out), .tc(tc), .zero(zero), .done(done)
  );

  mod_n_timer #(
    .NUM_DIGITS(2), .DIGIT_W(4), .MOD_LIST(8'h6A), .AUTO_RELOAD(1'b1)
  ) u_ar (
    .clk(clk), .clr(a_clr), .en(a_en), .loadn(a_loadn), .data(a_data),
    .out(a_out), .tc(a_tc), .zero(a_zero), .done(a_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; loadn = 1'b0; data = 16'h1234;
    a_clr = 1'b1; a_en = 1'b0; a_loadn = 1'b1; a_data = 8'h00;
    #1;

    // reset dominates a concurrent load
    step(); step();
    chk("rst_out",  out,  16'h0000);
    chk("rst_zero", zero, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_tc",   tc,   4'b0000);
    chk("ar_rst_out", a_out, 8'h00);
    clr = 1'b0; a_clr = 1'b0;
    step();
    chk("rst_release_load", out, 16'h1234);
    chk("rst_release_zero", zero, 1'b0);

    // 01:30 countdown
    data = 16'h0130; loadn = 1'b0;
    step();
    chk("mmss_load", out, 16'h0130);
    loadn = 1'b1; en = 1'b1;
    step();
    chk("mmss_t1_out", out, 16'h0129);
    chk("mmss_t1_tc",  tc,  4'b0001);
    for (int i = 2; i <= 30; i++) step();
    chk("mmss_t30_out", out, 16'h0100);
    step();
    chk("mmss_t31_out", out, 16'h0059);
    chk("mmss_t31_tc",  tc,  4'b0011);
    step();
    chk("mmss_t32_tc",  tc,  4'b0000);
    for (int i = 33; i <= 89; i++) step();
    chk("mmss_t89_out",  out,  16'h0001);
    chk("mmss_t89_done", done, 1'b0);
    step();
    chk("mmss_t90_out",  out,  16'h0000);
    chk("mmss_t90_zero", zero, 1'b1);
    chk("mmss_t90_done", done, 1'b1);
    step();
    chk("mmss_t91_out",  out,  16'h0000);
    chk("mmss_t91_done", done, 1'b0);
    chk("mmss_t91_tc",   tc,   4'b0000);

    // clamping of out-of-range digits
    en = 1'b0; data = 16'hC9F7; loadn = 1'b0;
    step();
    chk("clamp_out",  out,  16'h9957);
    chk("clamp_zero", zero, 1'b0);

    // hold with en low
    data = 16'h0042;
    step();
    loadn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("hold_out",  out,  16'h0042);
    chk("hold_done", done, 1'b0);

    // load beats the final tick
    data = 16'h0001; loadn = 1'b0;
    step();
    chk("prio_pre", out, 16'h0001);
    data = 16'h0005; en = 1'b1;
    step();
    chk("prio_out",  out,  16'h0005);
    chk("prio_done", done, 1'b0);

    // mid-count reset
    data = 16'h0500; loadn = 1'b0; en = 1'b0;
    step();
    loadn = 1'b1; en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("mid_out", out, 16'h0450);
    clr = 1'b1;
    step();
    chk("mid_clr_out",  out,  16'h0000);
    chk("mid_clr_zero", zero, 1'b1);
    clr = 1'b0;
    step(); step(); step();
    chk("mid_after_out",  out,  16'h0000);
    chk("mid_after_done", done, 1'b0);
    en = 1'b0;

    // auto-reload instance
    a_data = 8'h12; a_loadn = 1'b0;
    step();
    chk("ar_load", a_out, 8'h12);
    a_loadn = 1'b1; a_en = 1'b1;
    for (int i = 1; i <= 11; i++) step();
    chk("ar_t11_out",  a_out,  8'h01);
    chk("ar_t11_done", a_done, 1'b0);
    step();
    chk("ar_t12_out",  a_out,  8'h00);
    chk("ar_t12_done", a_done, 1'b1);
    chk("ar_t12_zero", a_zero, 1'b1);
    step();
    chk("ar_reload_out",  a_out,  8'h12);
    chk("ar_reload_done", a_done, 1'b0);
    chk("ar_reload_zero", a_zero, 1'b0);
    a_en = 1'b0; a_data = 8'h00; a_loadn = 1'b0;
    step();
    a_loadn = 1'b1; a_en = 1'b1;
    step();
    chk("ar_zero_out",  a_out,  8'h00);
    chk("ar_zero_zero", a_zero, 1'b1);
    chk("ar_zero_done", a_done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
